serial_adder_sub: RTL and testbench

- Parametrised, clocked successor to the single-bit combinational full adder.
- Adds or subtracts two WIDTH-bit operands bit-serially, LSB first, through one full-adder cell and a carry flip-flop.
- Start/done handshake plus a small FSM and bit counter.
- Serves as a low-area arithmetic unit for datapaths where latency is traded for gate count.

---
 rtl/serial_adder_sub.sv | 92 +++++++++
 tb/tb_serial_adder_sub.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_sub.sv
// rtl/serial_adder_sub.sv - bit-serial WIDTH-bit adder/subtractor, LSB first, one full-adder cell
module serial_adder_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] sr;
    logic             c;
    logic [CW-1:0]    cnt;

    logic             bit_s;
    logic             c_next;
    logic [WIDTH-1:0] sr_next;

    always_comb begin
        bit_s   = sa[0] ^ sb[0] ^ c;
        c_next  = (sa[0] & sb[0]) | (sa[0] & c) | (sb[0] & c);
        // new bit enters at the MSB so the LSB-first stream lands in place after WIDTH shifts
        sr_next = (sr >> 1) | (WIDTH'(bit_s) << (WIDTH - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sa    <= '0;
            sb    <= '0;
            sr    <= '0;
            c     <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sa    <= a;
                        sb    <= sub ? ~b : b;
                        c     <= sub ? 1'b1 : cin;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    sr  <= sr_next;
                    c   <= c_next;
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        // c is the carry into the MSB, c_next the carry out of it
                        sum   <= sr_next;
                        cout  <= c_next;
                        ovf   <= c ^ c_next;
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_serial_adder_sub.sv
// tb/tb_serial_adder_sub.sv - vector table and scoreboard bench for serial_adder_sub at WIDTH 8 and 1
module tb_serial_adder_sub;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       sub;
        logic       cin;
        logic [7:0] s;
        logic       co;
        logic       ov;
    } vec_t;

    typedef struct packed {
        logic [7:0] s;
        logic       co;
        logic       ov;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       start8 = 1'b0, sub8 = 1'b0, cin8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic [7:0] sum8;
    logic       cout8, ovf8, busy8, done8;

    logic       start1 = 1'b0, sub1 = 1'b0, cin1 = 1'b0;
    logic [0:0] a1 = '0, b1 = '0;
    logic [0:0] sum1;
    logic       cout1, ovf1, busy1, done1;

    int checks = 0;
    int failures = 0;

    exp_t q8[$];
    exp_t q1[$];

    serial_adder_sub #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8), .a(a8), .b(b8), .cin(cin8),
        .sum(sum8), .cout(cout8), .ovf(ovf8), .busy(busy8), .done(done8)
    );

    serial_adder_sub #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .sub(sub1), .a(a1), .b(b1), .cin(cin1),
        .sum(sum1), .cout(cout1), .ovf(ovf1), .busy(busy1), .done(done1)
    );

    always #5 clk = ~clk;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endfunction

    // Independent reference: signed and unsigned integer arithmetic
    function automatic exp_t model8(logic [7:0] a, logic [7:0] b, logic s, logic c);
        exp_t e;
        int   ua, ub, ia, ib, r, ir;
        ua = int'(a);
        ub = int'(b);
        ia = (ua > 127) ? ua - 256 : ua;
        ib = (ub > 127) ? ub - 256 : ub;
        if (s) begin
            r  = ua - ub;
            ir = ia - ib;
            e.co = (ua >= ub);
        end else begin
            r  = ua + ub + int'(c);
            ir = ia + ib + int'(c);
            e.co = (r > 255);
        end
        e.s  = 8'(r);
        e.ov = (ir > 127) || (ir < -128);
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_n && done8) begin
            if (q8.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done8 actual=1 required=0");
            end else begin
                exp_t e;
                e = q8.pop_front();
                check("sum8", 64'(sum8), 64'(e.s));
                check("cout8", 64'(cout8), 64'(e.co));
                check("ovf8", 64'(ovf8), 64'(e.ov));
            end
        end
        if (rst_n && done1) begin
            if (q1.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done1 actual=1 required=0");
            end else begin
                exp_t e;
                e = q1.pop_front();
                check("sum1", 64'(sum1), 64'(e.s[0]));
                check("cout1", 64'(cout1), 64'(e.co));
            end
        end
    end

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s, input logic c,
                       input exp_t e);
        int lat;
        int bcnt;
        @(negedge clk);
        a8 = a; b8 = b; sub8 = s; cin8 = c; start8 = 1'b1;
        q8.push_back(e);
        @(posedge clk);
        #1;
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom); cin8 = 1'($urandom);
        lat = -1;
        bcnt = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (done8) begin
                lat = i - 1;
                break;
            end
            if (busy8) bcnt++;
        end
        check("latency8", 64'(lat), 64'(8));
        check("busy_cycles8", 64'(bcnt), 64'(8));
        @(negedge clk);
        check("done_pulse8", 64'(done8), 64'(0));
    endtask

    task automatic op1(input logic a, input logic b, input logic c, input exp_t e);
        int lat;
        @(negedge clk);
        a1 = a; b1 = b; sub1 = 1'b0; cin1 = c; start1 = 1'b1;
        q1.push_back(e);
        @(posedge clk);
        #1;
        start1 = 1'b0;
        a1 = ~a; b1 = ~b; cin1 = ~c;
        lat = -1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (done1) begin
                lat = i - 1;
                break;
            end
        end
        check("latency1", 64'(lat), 64'(1));
        @(negedge clk);
        check("done_pulse1", 64'(done1), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tv[9];
        exp_t e;
        exp_t first;
        tv[0] = '{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0};
        tv[1] = '{8'hFF, 8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0};
        tv[2] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
        tv[3] = '{8'h05, 8'h07, 1'b1, 1'b0, 8'hFE, 1'b0, 1'b0};
        tv[4] = '{8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1};
        tv[5] = '{8'h3C, 8'h3C, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
        tv[6] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
        tv[7] = '{8'h00, 8'h01, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0};
        tv[8] = '{8'h10, 8'h01, 1'b1, 1'b1, 8'h0F, 1'b1, 1'b0};

        repeat (3) @(negedge clk);
        check("rst_sum8", 64'(sum8), 64'(0));
        check("rst_flags8", 64'({cout8, ovf8, busy8, done8}), 64'(0));
        check("rst_out1", 64'({sum1, cout1, ovf1, busy1, done1}), 64'(0));
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            e.s = tv[i].s; e.co = tv[i].co; e.ov = tv[i].ov;
            op8(tv[i].a, tv[i].b, tv[i].sub, tv[i].cin, e);
        end

        for (int i = 0; i < 6; i++) begin
            logic [7:0] ra, rb;
            logic rs, rc;
            ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom); rc = 1'($urandom);
            op8(ra, rb, rs, rc, model8(ra, rb, rs, rc));
        end

        // start held high: second accept must land exactly WIDTH+2 edges after the first
        @(negedge clk);
        a8 = 8'hA5; b8 = 8'h3C; sub8 = 1'b0; cin8 = 1'b0; start8 = 1'b1;
        first = '{8'hE1, 1'b0, 1'b0};
        q8.push_back(first);
        @(posedge clk);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (k == 9) check("hold_done_k9", 64'(done8), 64'(1));
            a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom); cin8 = 1'($urandom);
        end
        @(negedge clk);
        check("hold_idle_k10", 64'({busy8, done8}), 64'(0));
        a8 = 8'h40; b8 = 8'h40; sub8 = 1'b0; cin8 = 1'b1;
        q8.push_back('{8'h81, 1'b0, 1'b1});
        @(posedge clk);
        #1;
        start8 = 1'b0;
        a8 = 8'h00; b8 = 8'h00;
        @(negedge clk);
        check("hold_busy_k11", 64'(busy8), 64'(1));
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            check("hold_sum_stable", 64'(sum8), 64'(first.s));
        end
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if (done8) begin
                    seen = 1;
                    break;
                end
            end
            check("hold_second_done", 64'(seen), 64'(1));
        end
        @(negedge clk);

        // asynchronous reset in the 4th RUN cycle
        @(negedge clk);
        a8 = 8'h55; b8 = 8'h22; sub8 = 1'b0; cin8 = 1'b0; start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        repeat (4) @(negedge clk);
        check("prereset_busy", 64'(busy8), 64'(1));
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_sum", 64'(sum8), 64'(0));
        check("async_rst_flags", 64'({cout8, ovf8, busy8, done8}), 64'(0));
        q8.delete();
        @(negedge clk);
        check("rst_held_idle", 64'({busy8, done8}), 64'(0));
        rst_n = 1'b1;
        op8(8'h12, 8'h34, 1'b0, 1'b0, '{8'h46, 1'b0, 1'b0});

        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            logic [1:0] r;
            v = 3'(i);
            r = 2'(v[2]) + 2'(v[1]) + 2'(v[0]);
            e.s = {7'b0, r[0]}; e.co = r[1]; e.ov = 1'b0;
            op1(v[2], v[1], v[0], e);
        end

        repeat (2) @(negedge clk);
        check("q8_drained", 64'(q8.size()), 64'(0));
        check("q1_drained", 64'(q1.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
